// File: rtl/sram_arbiter.sv
// sram_arbiter: shares the external 16-bit asynchronous SRAM between the CPU
// program-RAM port and a byte-wide loader/DMA master, sequencing timed cycles.
module sram_arbiter #(
  parameter int unsigned RD_CYCLES = 2,
  parameter int unsigned WR_CYCLES = 2
) (
  input  logic        clk,
  input  logic        n_reset,
  input  logic        cpu_req,
  input  logic        cpu_we,
  input  logic [19:0] cpu_addr,
  input  logic [7:0]  cpu_wdata,
  output logic [7:0]  cpu_rdata,
  output logic        cpu_ack,
  input  logic        dma_req,
  input  logic        dma_we,
  input  logic [19:0] dma_addr,
  input  logic [7:0]  dma_wdata,
  output logic [7:0]  dma_rdata,
  output logic        dma_ack,
  output logic [18:0] sram_a,
  inout  wire  [15:0] sram_d,
  output logic        sram_wel,
  output logic        sram_lbl,
  output logic        sram_ubl
);

  localparam logic [2:0] S_IDLE     = 3'd0;
  localparam logic [2:0] S_RD       = 3'd1;
  localparam logic [2:0] S_WR_SETUP = 3'd2;
  localparam logic [2:0] S_WR_PULSE = 3'd3;
  localparam logic [2:0] S_WR_HOLD  = 3'd4;
  localparam logic [2:0] S_DONE     = 3'd5;

  localparam int unsigned RD_N = (RD_CYCLES == 0) ? 1 : RD_CYCLES;
  localparam int unsigned WR_N = (WR_CYCLES == 0) ? 1 : WR_CYCLES;

  localparam logic GNT_CPU = 1'b0;
  localparam logic GNT_DMA = 1'b1;

  logic [2:0]  state;
  logic [15:0] cnt;
  logic        gnt;
  logic        last_grant;
  logic        lane;
  logic        drive_en;
  logic [7:0]  wdata_q;

  logic        any_req;
  logic        pick_dma;
  logic        sel_we;
  logic [19:0] sel_addr;
  logic [7:0]  sel_wdata;
  logic [7:0]  rd_byte;

  // On a tie the master not served last wins, giving strict alternation.
  always_comb begin
    any_req   = cpu_req | dma_req;
    pick_dma  = (cpu_req && dma_req) ? (last_grant == GNT_CPU) : dma_req;
    sel_we    = pick_dma ? dma_we    : cpu_we;
    sel_addr  = pick_dma ? dma_addr  : cpu_addr;
    sel_wdata = pick_dma ? dma_wdata : cpu_wdata;
    rd_byte   = lane ? sram_d[15:8] : sram_d[7:0];
  end

  assign sram_d = drive_en ? {wdata_q, wdata_q} : 'z;

  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      state      <= S_IDLE;
      cnt        <= '0;
      gnt        <= GNT_CPU;
      last_grant <= GNT_DMA;
      lane       <= 1'b0;
      drive_en   <= 1'b0;
      wdata_q    <= '0;
      sram_a     <= '0;
      sram_wel   <= 1'b1;
      sram_lbl   <= 1'b1;
      sram_ubl   <= 1'b1;
      cpu_ack    <= 1'b0;
      dma_ack    <= 1'b0;
      cpu_rdata  <= '0;
      dma_rdata  <= '0;
    end else begin
      cpu_ack <= 1'b0;
      dma_ack <= 1'b0;
      case (state)
        S_IDLE: begin
          if (any_req) begin
            gnt        <= pick_dma;
            last_grant <= pick_dma;
            sram_a     <= sel_addr[19:1];
            lane       <= sel_addr[0];
            sram_lbl   <= sel_addr[0];
            sram_ubl   <= ~sel_addr[0];
            wdata_q    <= sel_wdata;
            cnt        <= '0;
            if (sel_we) begin
              drive_en <= 1'b1;
              state    <= S_WR_SETUP;
            end else begin
              state    <= S_RD;
            end
          end
        end
        S_RD: begin
          if (cnt == 16'(RD_N - 1)) begin
            sram_lbl <= 1'b1;
            sram_ubl <= 1'b1;
            state    <= S_DONE;
            if (gnt == GNT_DMA) begin
              dma_ack   <= 1'b1;
              dma_rdata <= rd_byte;
            end else begin
              cpu_ack   <= 1'b1;
              cpu_rdata <= rd_byte;
            end
          end else begin
            cnt <= cnt + 16'd1;
          end
        end
        S_WR_SETUP: begin
          sram_wel <= 1'b0;
          cnt      <= '0;
          state    <= S_WR_PULSE;
        end
        S_WR_PULSE: begin
          if (cnt == 16'(WR_N - 1)) begin
            sram_wel <= 1'b1;
            state    <= S_WR_HOLD;
          end else begin
            cnt <= cnt + 16'd1;
          end
        end
        S_WR_HOLD: begin
          sram_lbl <= 1'b1;
          sram_ubl <= 1'b1;
          drive_en <= 1'b0;
          state    <= S_DONE;
          if (gnt == GNT_DMA) dma_ack <= 1'b1;
          else                cpu_ack <= 1'b1;
        end
        S_DONE:  state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sram_arbiter.sv
// Bench for sram_arbiter: SRAM device model, transaction-level timeline
// reference, directed scenarios and randomized two-master traffic.
module tb_sram_arbiter;

  localparam int unsigned RD_N = 2;
  localparam int unsigned WR_N = 2;

  logic clk = 1'b0;
  always #20 clk = ~clk;

  logic        n_reset;
  logic        cpu_req, cpu_we, cpu_ack;
  logic [19:0] cpu_addr;
  logic [7:0]  cpu_wdata, cpu_rdata;
  logic        dma_req, dma_we, dma_ack;
  logic [19:0] dma_addr;
  logic [7:0]  dma_wdata, dma_rdata;
  logic [18:0] sram_a;
  wire  [15:0] sram_d;
  logic        sram_wel, sram_lbl, sram_ubl;

  sram_arbiter #(.RD_CYCLES(RD_N), .WR_CYCLES(WR_N)) dut (
    .clk(clk), .n_reset(n_reset),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_rdata(cpu_rdata), .cpu_ack(cpu_ack),
    .dma_req(dma_req), .dma_we(dma_we), .dma_addr(dma_addr), .dma_wdata(dma_wdata),
    .dma_rdata(dma_rdata), .dma_ack(dma_ack),
    .sram_a(sram_a), .sram_d(sram_d), .sram_wel(sram_wel),
    .sram_lbl(sram_lbl), .sram_ubl(sram_ubl)
  );

  // Second instance with short/zero cycle parameters.
  logic        p_req, p_we, p_ack, p_dack, p_oe;
  logic [19:0] p_addr;
  logic [7:0]  p_wdata, p_rdata, p_drdata;
  logic [18:0] p_sram_a;
  wire  [15:0] p_sram_d;
  logic        p_wel, p_lbl, p_ubl;

  sram_arbiter #(.RD_CYCLES(1), .WR_CYCLES(0)) dut_p (
    .clk(clk), .n_reset(n_reset),
    .cpu_req(p_req), .cpu_we(p_we), .cpu_addr(p_addr), .cpu_wdata(p_wdata),
    .cpu_rdata(p_rdata), .cpu_ack(p_ack),
    .dma_req(1'b0), .dma_we(1'b0), .dma_addr(20'h0), .dma_wdata(8'h0),
    .dma_rdata(p_drdata), .dma_ack(p_dack),
    .sram_a(p_sram_a), .sram_d(p_sram_d), .sram_wel(p_wel),
    .sram_lbl(p_lbl), .sram_ubl(p_ubl)
  );
  assign p_sram_d = p_oe ? 16'h5AC3 : 'z;

  // SRAM device model; drives the bus whenever the DUT is not expected to.
  logic [15:0] mem     [0:63];
  logic [15:0] ref_mem [0:63];
  logic [15:0] mdl_q;
  logic        win_cur, win_nxt;
  assign mdl_q  = (sram_wel && (!sram_lbl || !sram_ubl)) ? mem[sram_a[5:0]] : 16'h0000;
  assign sram_d = !(win_cur || win_nxt) ? mdl_q : 'z;

  always @(posedge clk) begin
    if (!sram_wel) begin
      if (!sram_lbl) mem[sram_a[5:0]][7:0]  <= sram_d[7:0];
      if (!sram_ubl) mem[sram_a[5:0]][15:8] <= sram_d[15:8];
    end
  end

  int unsigned checks = 0;
  int unsigned failures = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h expected=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference: each access occupies a fixed window measured from its grant cycle.
  bit          mon_en = 1'b0;
  bit          busy, ref_last_dma;
  int unsigned cyc = 0, g_cyc, len;
  bit          cur_dma, cur_we;
  logic [19:0] cur_addr;
  logic [7:0]  cur_wd, cur_rd, exp_cpu_rd, exp_dma_rd;
  logic [18:0] ref_a;

  task automatic ref_reset();
    busy = 1'b0; ref_last_dma = 1'b1;
    exp_cpu_rd = '0; exp_dma_rd = '0; ref_a = '0;
    win_cur = 1'b0; win_nxt = 1'b0;
  endtask

  always @(negedge clk) begin : monitor
    int unsigned k, kn;
    bit was_busy, e_wel, e_lbl, e_ubl, e_cack, e_dack, e_drv;
    if (mon_en) begin
      e_wel = 1'b1; e_lbl = 1'b1; e_ubl = 1'b1;
      e_cack = 1'b0; e_dack = 1'b0; e_drv = 1'b0;
      was_busy = busy;
      k = cyc - g_cyc;
      if (busy) begin
        if (k == len) begin
          if (cur_dma) e_dack = 1'b1; else e_cack = 1'b1;
          if (!cur_we) begin
            if (cur_dma) exp_dma_rd = cur_rd; else exp_cpu_rd = cur_rd;
          end
        end else if (k >= 1) begin
          e_lbl = cur_addr[0];
          e_ubl = !cur_addr[0];
          if (cur_we) begin
            e_drv = 1'b1;
            if (k >= 2 && k <= WR_N + 1) e_wel = 1'b0;
          end
        end
      end
      check("cpu_ack", cpu_ack, e_cack);
      check("dma_ack", dma_ack, e_dack);
      check("wel", sram_wel, e_wel);
      check("lbl", sram_lbl, e_lbl);
      check("ubl", sram_ubl, e_ubl);
      check("addr", sram_a, ref_a);
      check("cpu_rdata", cpu_rdata, exp_cpu_rd);
      check("dma_rdata", dma_rdata, exp_dma_rd);
      if (e_drv) check("bus_write", sram_d, {cur_wd, cur_wd});
      else       check("bus_release", sram_d, mdl_q);
      if (busy && k == len) busy = 1'b0;
      if (!was_busy && (cpu_req || dma_req)) begin
        cur_dma  = (cpu_req && dma_req) ? !ref_last_dma : dma_req;
        ref_last_dma = cur_dma;
        cur_we   = cur_dma ? dma_we    : cpu_we;
        cur_addr = cur_dma ? dma_addr  : cpu_addr;
        cur_wd   = cur_dma ? dma_wdata : cpu_wdata;
        g_cyc = cyc;
        len   = cur_we ? WR_N + 3 : RD_N + 1;
        busy  = 1'b1;
        ref_a = cur_addr[19:1];
        if (cur_we) begin
          if (cur_addr[0]) ref_mem[cur_addr[6:1]][15:8] = cur_wd;
          else             ref_mem[cur_addr[6:1]][7:0]  = cur_wd;
        end else begin
          cur_rd = cur_addr[0] ? ref_mem[cur_addr[6:1]][15:8] : ref_mem[cur_addr[6:1]][7:0];
        end
      end
      kn = cyc + 1 - g_cyc;
      win_cur = e_drv;
      win_nxt = busy && cur_we && kn >= 1 && kn <= WR_N + 2;
      cyc++;
    end
  end

  task automatic do_access(input bit dma, input bit we, input logic [19:0] addr,
                           input logic [7:0] wd, output int unsigned ack_n,
                           output logic [7:0] rd, output logic [15:0] wel_mask,
                           output logic [15:0] lane_mask);
    @(posedge clk); #1;
    if (dma) begin dma_req = 1'b1; dma_we = we; dma_addr = addr; dma_wdata = wd; end
    else     begin cpu_req = 1'b1; cpu_we = we; cpu_addr = addr; cpu_wdata = wd; end
    ack_n = 99; rd = '0; wel_mask = '0; lane_mask = '0;
    for (int n = 0; n < 16; n++) begin
      @(negedge clk);
      if (!sram_wel) wel_mask[n] = 1'b1;
      if ((addr[0] ? !sram_ubl : !sram_lbl) && sram_a == addr[19:1]) lane_mask[n] = 1'b1;
      if (dma ? dma_ack : cpu_ack) begin
        ack_n = n;
        rd = dma ? dma_rdata : cpu_rdata;
        break;
      end
    end
    @(posedge clk); #1;
    cpu_req = 1'b0; dma_req = 1'b0;
  endtask

  task automatic apply_reset();
    @(posedge clk); #1;
    mon_en = 1'b0; n_reset = 1'b0; ref_reset();
    repeat (2) @(posedge clk);
    #1 n_reset = 1'b1; mon_en = 1'b1;
  endtask

  task automatic new_req(input bit dma);
    bit r;
    r = ($urandom_range(0, 9) < 6);
    if (dma) begin
      dma_req = r; dma_we = 1'($urandom_range(0, 1));
      dma_addr = 20'($urandom); dma_wdata = 8'($urandom);
    end else begin
      cpu_req = r; cpu_we = 1'($urandom_range(0, 1));
      cpu_addr = 20'($urandom); cpu_wdata = 8'($urandom);
    end
  endtask

  initial begin
    int unsigned n, nacks;
    int unsigned order[4];
    int unsigned ackc[4];
    logic [7:0]  rd, exp_b;
    logic [15:0] wm, lm, pd;
    logic [19:0] ra;
    bit          ca, da, seen;

    foreach (mem[i]) begin mem[i] = '0; ref_mem[i] = '0; end
    p_req = 1'b0; p_we = 1'b0; p_addr = '0; p_wdata = '0; p_oe = 1'b0;
    ref_reset();

    // Reset held with both masters requesting.
    n_reset = 1'b0;
    cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 20'h00005; cpu_wdata = 8'h77;
    dma_req = 1'b1; dma_we = 1'b1; dma_addr = 20'h00008; dma_wdata = 8'h66;
    repeat (3) @(negedge clk);
    check("rst_wel", sram_wel, 1'b1);
    check("rst_lbl", sram_lbl, 1'b1);
    check("rst_ubl", sram_ubl, 1'b1);
    check("rst_bus", sram_d, 16'h0000);
    check("rst_cpu_ack", cpu_ack, 1'b0);
    check("rst_dma_ack", dma_ack, 1'b0);
    check("rst_addr", sram_a, 19'h0);
    check("rst_rdata", {cpu_rdata, dma_rdata}, 16'h0000);
    cpu_req = 1'b0; dma_req = 1'b0;
    @(posedge clk); #1 n_reset = 1'b1; mon_en = 1'b1;
    repeat (3) @(posedge clk);

    // CPU read of upper lane of word 1.
    mem[1] = 16'hA55A; ref_mem[1] = 16'hA55A;
    do_access(1'b0, 1'b0, 20'h00003, 8'h00, n, rd, wm, lm);
    check("rd_ack_cycle", n, 3);
    check("rd_data", rd, 8'hA5);
    check("rd_lane_cycles", lm, 16'b0000_0000_0000_0110);
    check("rd_dma_rdata", dma_rdata, 8'h00);

    // DMA write to low lane of word 8.
    mem[8] = 16'hC700; ref_mem[8] = 16'hC700;
    do_access(1'b1, 1'b1, 20'h00010, 8'h3C, n, rd, wm, lm);
    check("wr_ack_cycle", n, 5);
    check("wr_wel_cycles", wm, 16'b0000_0000_0000_1100);
    check("wr_lane_cycles", lm, 16'b0000_0000_0001_1110);
    check("wr_mem_word", mem[8], 16'hC73C);

    // Both masters saturated from reset: strict alternation, CPU first.
    apply_reset();
    @(posedge clk); #1;
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 20'($urandom);
    dma_req = 1'b1; dma_we = 1'b0; dma_addr = 20'($urandom);
    nacks = 0;
    for (int i = 0; i < 40 && nacks < 4; i++) begin
      @(negedge clk);
      if (cpu_ack) begin order[nacks] = 0; ackc[nacks] = i; nacks++; end
      if (dma_ack && nacks < 4) begin order[nacks] = 1; ackc[nacks] = i; nacks++; end
    end
    @(posedge clk); #1 cpu_req = 1'b0; dma_req = 1'b0;
    check("alt_count", nacks, 4);
    for (int i = 0; i < 4; i++) check("alt_order", order[i], i % 2);
    check("alt_first_ack", ackc[0], RD_N + 1);
    check("alt_span", ackc[3] - ackc[0], 3 * (RD_N + 2));

    // Asynchronous reset while sram_wel is low.
    ra = 20'h0002B;
    @(posedge clk); #1;
    dma_req = 1'b1; dma_we = 1'b1; dma_addr = ra; dma_wdata = 8'hE1;
    seen = 1'b0;
    for (int i = 0; i < 10 && !seen; i++) begin
      @(negedge clk);
      if (!sram_wel) seen = 1'b1;
    end
    check("pulse_seen", seen, 1'b1);
    #3 mon_en = 1'b0; n_reset = 1'b0; ref_reset();
    #1;
    check("abort_wel", sram_wel, 1'b1);
    check("abort_lanes", {sram_lbl, sram_ubl}, 2'b11);
    check("abort_bus", sram_d, 16'h0000);
    check("abort_ack", dma_ack, 1'b0);
    dma_req = 1'b0;
    repeat (2) begin
      @(negedge clk);
      check("abort_no_ack", {cpu_ack, dma_ack}, 2'b00);
    end
    @(posedge clk); #1 n_reset = 1'b1;
    foreach (mem[i]) ref_mem[i] = mem[i];
    mon_en = 1'b1;
    exp_b = ref_mem[ra[6:1]][15:8];
    do_access(1'b0, 1'b0, ra, 8'h00, n, rd, wm, lm);
    check("post_abort_ack", n, 3);
    check("post_abort_data", rd, exp_b);

    // Randomized traffic from both masters.
    for (int i = 0; i < 600; i++) begin
      @(negedge clk); ca = cpu_ack; da = dma_ack;
      @(posedge clk); #1;
      if (!cpu_req || ca) new_req(1'b0);
      if (!dma_req || da) new_req(1'b1);
    end
    for (int i = 0; i < 60 && (cpu_req || dma_req); i++) begin
      @(negedge clk); ca = cpu_ack; da = dma_ack;
      @(posedge clk); #1;
      if (ca) cpu_req = 1'b0;
      if (da) dma_req = 1'b0;
    end
    check("drain", {cpu_req, dma_req}, 2'b00);
    repeat (3) @(posedge clk);
    #1 mon_en = 1'b0;

    // RD_CYCLES=1, WR_CYCLES=0 instance.
    p_oe = 1'b1;
    @(posedge clk); #1 p_req = 1'b1; p_we = 1'b0; p_addr = 20'h00001;
    n = 99; rd = '0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (p_ack) begin n = i; rd = p_rdata; break; end
    end
    @(posedge clk); #1 p_req = 1'b0; p_oe = 1'b0;
    check("p_rd_ack_cycle", n, 2);
    check("p_rd_data", rd, 8'h5A);
    @(posedge clk); #1 p_req = 1'b1; p_we = 1'b1; p_addr = 20'h00000; p_wdata = 8'h96;
    n = 99; wm = '0; pd = '0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (!p_wel) begin wm[i] = 1'b1; pd = p_sram_d; end
      if (p_ack) begin n = i; break; end
    end
    @(posedge clk); #1 p_req = 1'b0;
    check("p_wr_ack_cycle", n, 4);
    check("p_wel_cycles", wm, 16'b0000_0000_0000_0100);
    check("p_wr_bus", pd, 16'h9696);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout got=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/sram_arbiter.md
# sram_arbiter

Two-port arbiter and cycle sequencer for the board's external 16-bit asynchronous SRAM (19-bit word address, active-low write enable and byte lanes). It sits between the UK101 core's program-RAM port and a second byte-wide master, such as a serial loader or DMA. It converts byte requests into correctly timed SRAM read and write cycles and shares the chip fairly between the two masters. All SRAM control outputs are registered.

## Interface
Parameters:
- RD_CYCLES, 2: cycles the address and lane are held before read data is sampled; 0 is treated as 1.
- WR_CYCLES, 2: width of the sram_wel low pulse in cycles; 0 is treated as 1.

Ports:
- clk  in  1  system clock (25 MHz pixel clock).
- n_reset  in  1  asynchronous, active-low reset.
- cpu_req  in  1  CPU request; held high until cpu_ack.
- cpu_we  in  1  1 = write, 0 = read; stable while cpu_req is high.
- cpu_addr  in  20  byte address; [19:1] is the word address, [0] is the lane.
- cpu_wdata  in  8  write byte.
- cpu_rdata  out  8  read byte; valid in the cpu_ack cycle and held until the next CPU read completes.
- cpu_ack  out  1  one-cycle completion pulse.
- dma_req, dma_we, dma_addr[19:0], dma_wdata[7:0], dma_rdata[7:0], dma_ack: second master, same rules as the CPU port.
- sram_a  out  19  SRAM word address.
- sram_d  inout  16  SRAM data bus.
- sram_wel  out  1  write enable, active low.
- sram_lbl  out  1  lower byte lane, d[7:0], active low.
- sram_ubl  out  1  upper byte lane, d[15:8], active low.

## Operation
- States: IDLE, RD, WR_SETUP, WR_PULSE, WR_HOLD, DONE.
- IDLE: samples both request lines.
  - One request pending: grant it.
  - Both pending: grant the master not granted last. last_grant resets to DMA, so the CPU wins the first tie.
  - On grant: latch addr, we and wdata; set sram_a = addr[19:1]; record last_grant.
- Lane select: addr[0]=0 drives sram_lbl low; addr[0]=1 drives sram_ubl low. The unselected lane stays high.
- RD: lane low, sram_wel high, bus released, for RD_CYCLES cycles. On the last RD cycle's clock edge, the selected half of sram_d goes into the granted master's rdata register. Next state DONE.
- WR_SETUP: 1 cycle. Lane low, sram_wel high, {wdata, wdata} driven on sram_d.
- WR_PULSE: WR_CYCLES cycles with sram_wel low. Data and lane held.
- WR_HOLD: 1 cycle. sram_wel high, data and lane still held. Next state DONE.
- DONE: both lanes high, sram_wel high, bus released. The granted master's ack is high for this single cycle. Next state IDLE.
- Requests are not sampled in DONE. A master that keeps req high after its ack cycle is making a new request.
- The other master's rdata is never modified.
- sram_d is driven only in WR_SETUP, WR_PULSE and WR_HOLD. It is Z in every other state, including reset.

## Timing
- Reset values: state IDLE, sram_wel=1, sram_lbl=1, sram_ubl=1, sram_a=0, sram_d=Z, cpu_ack=0, dma_ack=0, cpu_rdata=0, dma_rdata=0, last_grant=DMA.
- Read timeline (cycle 0 = IDLE cycle in which req is sampled):
  - RD in cycles 1..RD_CYCLES.
  - ack in cycle RD_CYCLES+1 (cycle 3 at default).
  - Next grant sampled in cycle RD_CYCLES+2.
- Write timeline:
  - WR_SETUP in cycle 1.
  - sram_wel low in cycles 2..WR_CYCLES+1.
  - WR_HOLD in cycle WR_CYCLES+2.
  - ack in cycle WR_CYCLES+3 (cycle 5 at default).
- Throughput:
  - A single saturated master gets one access every RD_CYCLES+2 cycles (read) or WR_CYCLES+4 cycles (write).
  - Two saturated masters strictly alternate, so neither waits more than one foreign access.
- Address, lane and data are stable at least one cycle before sram_wel falls and one cycle after it rises.
- Reset asserted mid-cycle: all outputs return to reset values immediately (asynchronous), sram_wel rises, the bus is released, and no ack is issued. The aborted write may or may not have landed.
- A request dropped before its ack is a protocol violation. Behaviour is undefined, but the FSM still finishes its cycle and returns to IDLE.

## Test plan
- Reset: hold n_reset low with requests active -> wel/lbl/ubl=1, sram_d=Z, both acks 0. Release -> IDLE, no spurious access.
- CPU read, addr 0x00003, SRAM model word 1 = 0xA55A, defaults:
  - sram_a=1 and sram_ubl low in cycles 1-2.
  - cpu_ack in cycle 3 with cpu_rdata=0xA5.
  - dma_rdata unchanged.
- DMA write 0x3C to addr 0x00010, defaults:
  - sram_a=8, lbl low, ubl high.
  - wel low exactly in cycles 2-3, sram_d[7:0]=0x3C from cycle 1 to 4.
  - dma_ack in cycle 5. Model low byte = 0x3C, high byte untouched.
- Both masters request simultaneously right after reset, back-to-back -> grant order CPU, DMA, CPU, DMA, with one DONE cycle between accesses.
- Reset pulse during WR_PULSE -> sram_wel high asynchronously, bus Z, no ack. A following request completes normally.
- RD_CYCLES=1, WR_CYCLES=0 -> read ack in cycle 2; write wel pulse 1 cycle wide, ack in cycle 4.
